// File: rtl/note_stabilizer.sv
// note_stabilizer: debounces raw pitch-detector notes into a stable note code.
// Optional macro NOTE_HYST_EN: release to Z needs RELEASE_COUNT Z samples.
module note_stabilizer #(
  parameter int unsigned CONFIRM_COUNT   = 3,
  parameter int unsigned RELEASE_COUNT   = 6,
  parameter logic [23:0] SILENCE_TIMEOUT = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] raw_note,
  input  logic       raw_valid,
  output logic [3:0] current_note,
  output logic       note_change,
  output logic       locked
);

  localparam logic [3:0]  CONF_T  = 4'(CONFIRM_COUNT);
  localparam logic [3:0]  REL_T   = 4'(RELEASE_COUNT);
  localparam logic [23:0] SIL_MAX = SILENCE_TIMEOUT;
  localparam logic [23:0] SIL_HIT = SILENCE_TIMEOUT - 24'd1;

`ifdef NOTE_HYST_EN
  localparam logic HYST = 1'b1;
`else
  localparam logic HYST = 1'b0;
`endif

  logic [3:0]  cur_q, cur_d;
  logic [3:0]  cand_q, cand_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [23:0] sil_q, sil_d;
  logic        chg_q, chg_d;

  logic [3:0] s;
  logic [3:0] thr;
  logic [3:0] cnt_inc;

  // Map unused codes to Z and pick the run length needed for this sample.
  always_comb begin
    s = raw_note;
    case (raw_note)
      4'd6, 4'd14, 4'd15: s = 4'd0;
      default:            s = raw_note;
    endcase
    thr = CONF_T;
    if (HYST && (s == 4'd0) && (cur_q != 4'd0)) begin
      thr = REL_T;
    end
    cnt_inc = cnt_q + 4'd1;
  end

  // Candidate tracking, silence timeout and change detection.
  always_comb begin
    cur_d  = cur_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    sil_d  = sil_q;
    if (raw_valid) begin
      sil_d = 24'd0;
      if (s == cur_q) begin
        cand_d = cur_q;
        cnt_d  = 4'd0;
      end else if (s == cand_q) begin
        if (cnt_inc >= thr) begin
          cur_d = s;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cand_d = s;
        if (thr > 4'd1) begin
          cnt_d = 4'd1;
        end else begin
          cur_d = s;
          cnt_d = 4'd0;
        end
      end
    end else begin
      if (sil_q != SIL_MAX) begin
        sil_d = sil_q + 24'd1;
      end
      if (sil_q >= SIL_HIT) begin
        cur_d  = 4'd0;
        cand_d = 4'd0;
        cnt_d  = 4'd0;
      end
    end
    chg_d = (cur_d != cur_q);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_q  <= 4'd0;
      cand_q <= 4'd0;
      cnt_q  <= 4'd0;
      sil_q  <= 24'd0;
      chg_q  <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      sil_q  <= sil_d;
      chg_q  <= chg_d;
    end
  end

  assign current_note = cur_q;
  assign note_change  = chg_q;
  assign locked       = (cur_q != 4'd0);

endmodule
